// File: rtl/l_frag_cfg.sv
// l_frag_cfg -- serially configured K-input LUT fragment.
//
// A 2^K-bit configuration word is shifted in one bit per clock while cfgEn is
// high.  A small FSM counts the bits of the current load; the LUT outputs are
// live only once a full word has arrived.  The bit falling off the bottom of
// the config register is presented on cfgDout so fragments can be chained.
//
// Ports:
//   QCK        in   clock, everything updates on its rising edge
//   QRT        in   synchronous active-high reset
//   cfgEn      in   config shift enable
//   cfgDin     in   serial config data in
//   cfgDout    out  serial config data out (current CFG[0])
//   cfgDone    out  registered, high while a complete word is loaded
//   I[K-1:0]   in   LUT select, I[0] is the table index LSB
//   QEN        in   output register enable
//   LUTOutput  out  combinational CFG[I] (0 until loaded)
//   CarryOut   out  combinational upper-half lookup CFG[{1,I[K-2:0]}]
//   QZ         out  registered LUT result
module l_frag_cfg #(
    parameter int K     = 4,
    parameter int CNT_W = K + 1
) (
    input  logic         QCK,
    input  logic         QRT,
    input  logic         cfgEn,
    input  logic         cfgDin,
    output logic         cfgDout,
    output logic         cfgDone,
    input  logic [K-1:0] I,
    input  logic         QEN,
    output logic         LUTOutput,
    output logic         CarryOut,
    output logic         QZ
);

    localparam int N = 1 << K;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        LOADED  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [N-1:0]     cfg_r;
    logic             cfg_done_r;
    logic             qz_r;
    logic             lut_s;
    logic             carry_s;
    logic [K-1:0]     carry_idx_s;

    // Next-state and bit-count logic for the configuration load FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            EMPTY: begin
                if (cfgEn) begin
                    state_next_s = LOADING;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            LOADING: begin
                if (cfgEn) begin
                    cnt_next_s = cnt_r + CNT_ONE;
                    // The shift that brings the count to N completes the word.
                    if (cnt_r == CNT_LAST) begin
                        state_next_s = LOADED;
                    end else begin
                        state_next_s = LOADING;
                    end
                end else begin
                    state_next_s = LOADING;
                end
            end
            LOADED: begin
                // Any further shift starts a fresh load; the old word is gone.
                if (cfgEn) begin
                    state_next_s = LOADING;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    state_next_s = LOADED;
                end
            end
            default: begin
                state_next_s = EMPTY;
                cnt_next_s   = '0;
            end
        endcase
    end

    // FSM state, bit count and done flag registers.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            state_r    <= EMPTY;
            cnt_r      <= '0;
            cfg_done_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            cfg_done_r <= (state_next_s == LOADED);
        end
    end

    // Config shift register: new bits enter at the top, CFG[0] leaves first.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            cfg_r <= '0;
        end else if (cfgEn) begin
            cfg_r <= {cfgDin, cfg_r[N-1:1]};
        end
    end

    // Table lookups, forced to 0 until a complete word is present.
    always_comb begin
        lut_s       = 1'b0;
        carry_s     = 1'b0;
        carry_idx_s = {1'b1, I[K-2:0]};
        if (state_r == LOADED) begin
            lut_s   = cfg_r[I];
            carry_s = cfg_r[carry_idx_s];
        end else begin
            lut_s   = 1'b0;
            carry_s = 1'b0;
        end
    end

    // Output register: captures only from a stable, fully loaded table.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            qz_r <= 1'b0;
        end else if (QEN && (state_r == LOADED) && !cfgEn) begin
            qz_r <= lut_s;
        end
    end

    assign cfgDout   = cfg_r[0];
    assign cfgDone   = cfg_done_r;
    assign LUTOutput = lut_s;
    assign CarryOut  = carry_s;
    assign QZ        = qz_r;

endmodule

// File: tb/tb_l_frag_cfg.sv
module tb_l_frag_cfg;

    logic       QCK = 1'b0;
    logic       QRT, cfgEn, cfgDin, QEN;
    logic [3:0] I;
    logic       u_dout, u_done, u_lut, u_carry, u_qz;
    logic       d_dout, d_done, d_lut, d_carry, d_qz;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #50 QCK = ~QCK;

    l_frag_cfg #(.K(4)) dut_up (
        .QCK(QCK), .QRT(QRT), .cfgEn(cfgEn), .cfgDin(cfgDin),
        .cfgDout(u_dout), .cfgDone(u_done), .I(I), .QEN(QEN),
        .LUTOutput(u_lut), .CarryOut(u_carry), .QZ(u_qz)
    );

    l_frag_cfg #(.K(4)) dut_dn (
        .QCK(QCK), .QRT(QRT), .cfgEn(cfgEn), .cfgDin(u_dout),
        .cfgDout(d_dout), .cfgDone(d_done), .I(I), .QEN(QEN),
        .LUTOutput(d_lut), .CarryOut(d_carry), .QZ(d_qz)
    );

    // Reference model: index 0 = upstream fragment, 1 = downstream fragment.
    logic [15:0] m_cfg [2];
    int          m_bits [2];   // bits received in the current load
    bit          m_ld [2];     // a full 16-bit word is in place
    logic        m_qz [2];

    function automatic logic m_lut(input int u, input logic [3:0] idx);
        if (!m_ld[u]) return 1'b0;
        return m_cfg[u][idx];
    endfunction

    function automatic logic m_carry(input int u, input logic [3:0] idx);
        int j;
        j = 8 + (int'(idx) % 8);
        if (!m_ld[u]) return 1'b0;
        return m_cfg[u][j];
    endfunction

    function automatic void m_shift(input int u, input logic b);
        m_cfg[u] = {b, m_cfg[u][15:1]};
        // A shift on a loaded fragment discards the word and counts as bit 1.
        if (m_ld[u]) begin
            m_ld[u]   = 1'b0;
            m_bits[u] = 0;
        end
        m_bits[u] = m_bits[u] + 1;
        if (m_bits[u] == 16) m_ld[u] = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one clock edge and advance the model with the same inputs.
    task automatic tick(input logic rst, input logic en, input logic din, input logic qen);
        logic up_out;
        QRT = rst; cfgEn = en; cfgDin = din; QEN = qen;
        @(posedge QCK);
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_cfg[u] = 16'h0000; m_bits[u] = 0; m_ld[u] = 1'b0; m_qz[u] = 1'b0;
            end
        end else begin
            up_out = m_cfg[0][0];
            for (int u = 0; u < 2; u++)
                if (qen && m_ld[u] && !en) m_qz[u] = m_lut(u, I);
            if (en) begin
                m_shift(0, din);
                m_shift(1, up_out);
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".done"},  {15'd0, u_done},  {15'd0, m_ld[0]});
        check({tag, ".lut"},   {15'd0, u_lut},   {15'd0, m_lut(0, I)});
        check({tag, ".carry"}, {15'd0, u_carry}, {15'd0, m_carry(0, I)});
        check({tag, ".qz"},    {15'd0, u_qz},    {15'd0, m_qz[0]});
        check({tag, ".dout"},  {15'd0, u_dout},  {15'd0, m_cfg[0][0]});
        check({tag, ".dn_done"}, {15'd0, d_done}, {15'd0, m_ld[1]});
        check({tag, ".dn_qz"},   {15'd0, d_qz},   {15'd0, m_qz[1]});
        check({tag, ".dn_dout"}, {15'd0, d_dout}, {15'd0, m_cfg[1][0]});
    endtask

    // Combinational sweep of I without any clock edge; returns the tables read back.
    task automatic sweep(input string tag, output logic [15:0] up_tab, output logic [15:0] dn_tab);
        for (int i = 0; i < 16; i++) begin
            I = 4'(i);
            #1;
            up_tab[i] = u_lut;
            dn_tab[i] = d_lut;
            check({tag, ".lut"},      {15'd0, u_lut},   {15'd0, m_lut(0, I)});
            check({tag, ".carry"},    {15'd0, u_carry}, {15'd0, m_carry(0, I)});
            check({tag, ".dn_lut"},   {15'd0, d_lut},   {15'd0, m_lut(1, I)});
            check({tag, ".dn_carry"}, {15'd0, d_carry}, {15'd0, m_carry(1, I)});
        end
    endtask

    task automatic load(input logic [15:0] w, input int first, input int last);
        for (int b = first; b <= last; b++) tick(1'b0, 1'b1, w[b], 1'b0);
    endtask

    initial begin
        logic [15:0] up_tab, dn_tab, w;
        logic [31:0] stream;
        I = 4'd0;

        // Reset state.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("reset");
        check("reset.lut_const", {15'd0, u_lut}, 16'd0);
        check("reset.done_const", {15'd0, u_done}, 16'd0);

        // Load 0x8000: done only after the 16th shift, single hit at I=F.
        load(16'h8000, 0, 14);
        check_all("l8000.b15");
        load(16'h8000, 15, 15);
        check_all("l8000.b16");
        check("l8000.done_const", {15'd0, u_done}, 16'd1);
        sweep("l8000", up_tab, dn_tab);
        for (int i = 0; i < 16; i++) begin
            I = 4'(i);
            #1;
            check("l8000.lut_only_f", {15'd0, u_lut}, {15'd0, (i == 15)});
            check("l8000.carry_only_7", {15'd0, u_carry}, {15'd0, ((i % 8) == 7)});
        end

        // XOR4 table: QZ tracks parity of I with QEN=1 and holds with QEN=0.
        load(16'h6996, 0, 15);
        for (int i = 0; i < 16; i++) begin
            I = 4'(i);
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            check("xor.qz_parity", {15'd0, u_qz}, {15'd0, 1'($countones(i) % 2)});
            check_all("xor");
        end
        w = {15'd0, u_qz};
        for (int i = 0; i < 4; i++) begin
            I = 4'($urandom_range(0, 15));
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            check("xor.qz_hold", {15'd0, u_qz}, w);
        end

        // Split load with a pause: nothing visible until the 16th bit.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        w = 16'($urandom);
        load(w, 0, 7);
        for (int i = 0; i < 5; i++) begin
            I = 4'($urandom_range(0, 15));
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            check_all("pause");
            check("pause.lut_zero", {15'd0, u_lut}, 16'd0);
        end
        load(w, 8, 14);
        check_all("pause.b15");
        load(w, 15, 15);
        check_all("pause.b16");
        sweep("pause", up_tab, dn_tab);
        check("pause.table", up_tab, w);

        // Reload from all-ones with QEN=1: QZ holds, outputs drop next cycle.
        load(16'hFFFF, 0, 15);
        I = 4'd3;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("reload.qz_set", {15'd0, u_qz}, 16'd1);
        check("reload.dout_old", {15'd0, u_dout}, 16'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        check_all("reload");
        check("reload.done_low", {15'd0, u_done}, 16'd0);
        check("reload.lut_low", {15'd0, u_lut}, 16'd0);
        check("reload.qz_hold", {15'd0, u_qz}, 16'd1);

        // Reset in the middle of a load, then a clean load of 0x0001.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        load(16'($urandom), 0, 8);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check_all("midrst");
        check("midrst.qz_zero", {15'd0, u_qz}, 16'd0);
        load(16'h0001, 0, 15);
        sweep("l0001", up_tab, dn_tab);
        check("l0001.table", up_tab, 16'h0001);

        // Chain: 32 bits through both fragments.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        stream = $urandom;
        for (int b = 0; b < 32; b++) tick(1'b0, 1'b1, stream[b], 1'b0);
        check_all("chain");
        sweep("chain", up_tab, dn_tab);
        check("chain.dn_first16", dn_tab, stream[15:0]);
        check("chain.up_last16", up_tab, stream[31:16]);

        // Unknown select must not disturb the load sequence.
        I = 4'bxxxx;
        load(16'hA5C3, 0, 15);
        check("xsel.done", {15'd0, u_done}, {15'd0, m_ld[0]});
        check("xsel.dout", {15'd0, u_dout}, {15'd0, m_cfg[0][0]});
        I = 4'd0;
        sweep("xsel", up_tab, dn_tab);
        check("xsel.table", up_tab, 16'hA5C3);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            I = 4'($urandom_range(0, 15));
            tick(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom));
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/l_frag_cfg.md
L_FRAG_CFG -- requirements
Module: l_frag_cfg

Interface
REQ-001 Parameter K, default 4: LUT input count; legal range 2..6; N = 2^K config bits.
REQ-002 Parameter CNT_W, default K+1: bit-counter width, able to hold 0..N.
REQ-003 Port QCK  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port QRT  input  1  reset; synchronous and active-high.
REQ-005 Port cfgEn  input  1  config shift enable.
REQ-006 Port cfgDin  input  1  serial config data in.
REQ-007 Port cfgDout  output  1  serial config data out, for chaining fragments.
REQ-008 Port cfgDone  output  1  high when all N config bits are loaded.
REQ-009 Port I  input  K  LUT select inputs; I[0] is the LSB of the table index.
REQ-010 Port QEN  input  1  output register enable.
REQ-011 Port LUTOutput  output  1  combinational LUT result.
REQ-012 Port CarryOut  output  1  combinational upper-half table result.
REQ-013 Port QZ  output  1  registered LUT result.

Function
REQ-014 Config register CFG[N-1:0]; on a cycle with cfgEn=1, CFG shall shift to {cfgDin, CFG[N-1:1]}, so the first bit shifted in ends at CFG[0] after N shifts.
REQ-015 cfgDout shall equal CFG[0] combinationally; a chained fragment then receives the bit this fragment shifts out on that edge.
REQ-016 FSM states: EMPTY, LOADING, LOADED.
REQ-017 EMPTY + cfgEn=1 -> LOADING, count=1 (when N=1 does not apply, K>=2).
REQ-018 LOADING + cfgEn=1 -> count+1; on the shift that makes count=N, go to LOADED.
REQ-019 LOADING + cfgEn=0 -> hold state, count and CFG; no timeout.
REQ-020 LOADED + cfgEn=1 -> reload: LOADING, count=1, CFG shifts as normal.
REQ-021 LOADED + cfgEn=0 -> hold.
REQ-022 cfgDone shall be 1 only in LOADED; registered, so it rises the cycle after the Nth shift edge.
REQ-023 LUTOutput = CFG[I] when in LOADED, else 0.
REQ-024 CarryOut = CFG[{1'b1, I[K-2:0]}] when in LOADED, else 0; I[K-1] shall not affect it.
REQ-025 QZ <= LUTOutput on an edge with QEN=1, state LOADED and cfgEn=0.
REQ-026 QZ shall hold on every other non-reset edge, including QEN=1 during a reload.
REQ-027 X or Z on I shall not corrupt state; only the outputs may go X.

Reset
REQ-028 QRT=1 at an edge shall give CFG=0, count=0, state EMPTY, QZ=0.
REQ-029 With QRT=1: cfgDone=0, LUTOutput=0, CarryOut=0, cfgDout=0.
REQ-030 QRT shall dominate cfgEn and QEN in the same cycle.
REQ-031 QRT during LOADING shall discard the partial load; a full N-bit reload is then required.
REQ-032 No asynchronous behaviour; QRT is not sampled between edges.

Verification (K=4, N=16)
REQ-033 Reset, then shift 16 bits with bit0 of 0x8000 first, cfgDone rising the cycle after the 16th edge -> LUTOutput=1 only at I=4'hF, 0 elsewhere; CarryOut=1 only at I[2:0]=3'b111.
REQ-034 Load 0x6996 (XOR4), sweep I 0..15 with QEN=1 -> QZ equals the parity of I one cycle later; with QEN=0, QZ holds.
REQ-035 Shift 8 bits, hold cfgEn=0 for 5 cycles, shift the remaining 8 -> cfgDone=1 only after the 16th shift; outputs 0 before that.
REQ-036 LOADED with 0xFFFF, assert cfgEn one cycle with QEN=1 -> cfgDone=0 and LUTOutput=0 next cycle; QZ holds 1; cfgDout shows the old CFG[0]=1.
REQ-037 QRT asserted with cfgEn=1 at shift 10 -> state EMPTY, CFG=0, QZ=0; a following 16-bit load of 0x0001 gives LUTOutput=1 only at I=0.
REQ-038 Two chained instances, 32 bits shifted in -> the downstream CFG equals the first 16 bits sent, and the upstream CFG equals the last 16.
